// File: rtl/mbus_wr_arbiter.sv
// Write-channel arbiter in front of the DDR write-master port.
// Grants one frame-write channel at a time and steers the controller handshake to it.
module mbus_wr_arbiter #(
  parameter int CH_NUM          = 4,
  parameter int MEM_DQ_WIDTH    = 16,
  parameter int BURST_LENGTH    = 8,
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int ARB_MODE        = 0,
  parameter int TIMEOUT         = 1024
) (
  input  logic                                       i_axi_aclk,
  input  logic                                       i_rst,
  input  logic [CH_NUM-1:0]                          i_ch_wrq,
  input  logic [CH_NUM*CTRL_ADDR_WIDTH-1:0]          i_ch_waddr,
  input  logic [CH_NUM*MEM_DQ_WIDTH*BURST_LENGTH-1:0] i_ch_wdata,
  input  logic [CH_NUM-1:0]                          i_ch_wready,
  output logic [CH_NUM-1:0]                          o_ch_wsel,
  output logic [CH_NUM-1:0]                          o_ch_wdata_rq,
  output logic [CH_NUM-1:0]                          o_ch_wbusy,
  output logic                                       o_wrq,
  output logic [CTRL_ADDR_WIDTH-1:0]                 o_waddr,
  output logic [MEM_DQ_WIDTH*BURST_LENGTH-1:0]       o_wdata,
  output logic                                       o_wready,
  input  logic                                       i_wdata_rq,
  input  logic                                       i_wbusy,
  output logic                                       o_err
);

  localparam int DW = MEM_DQ_WIDTH * BURST_LENGTH;
  localparam int AW = CTRL_ADDR_WIDTH;
  localparam int GW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [GW-1:0]     grant;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     win;
  logic [CH_NUM-1:0] win_oh;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic              timeout_hit;
  logic              found;
  int                idx;
  logic [AW-1:0]     waddr_win;
  logic [DW-1:0]     wdata_g;
  logic              wready_g;
  logic              xfer;

  // Round-robin scans upward from the channel after the last grant.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    if (ARB_MODE == 1) begin
      for (int i = CH_NUM - 1; i >= 0; i--) begin
        if (i_ch_wrq[i]) win = GW'(i);
      end
    end else begin
      for (int i = 1; i <= CH_NUM; i++) begin
        idx = (int'(last_grant) + i) % CH_NUM;
        if (!found && i_ch_wrq[idx]) begin
          win   = GW'(idx);
          found = 1'b1;
        end
      end
    end
  end

  assign win_oh = CH_NUM'(1) << win;

  always_comb begin
    waddr_win = '0;
    wdata_g   = '0;
    wready_g  = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (win == GW'(i)) waddr_win = i_ch_waddr[i*AW +: AW];
      if (grant == GW'(i)) begin
        wdata_g  = i_ch_wdata[i*DW +: DW];
        wready_g = i_ch_wready[i];
      end
    end
  end

  assign cnt_inc     = cnt + CW'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (|i_ch_wrq) state_nxt = REQ;
      REQ: begin
        if (i_wbusy) state_nxt = XFER;
        else if (timeout_hit) state_nxt = IDLE;
      end
      XFER: if (!i_wbusy) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_axi_aclk) begin
    if (i_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(CH_NUM - 1);
      o_ch_wsel  <= '0;
      o_waddr    <= '0;
      o_wrq      <= 1'b0;
      o_err      <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      o_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|i_ch_wrq) begin
            grant     <= win;
            o_ch_wsel <= win_oh;
            o_waddr   <= waddr_win;
            o_wrq     <= 1'b1;
            cnt       <= '0;
          end
        end
        REQ: begin
          cnt <= cnt_inc;
          if (i_wbusy) begin
            o_wrq <= 1'b0;
          end else if (timeout_hit) begin
            o_wrq      <= 1'b0;
            o_err      <= 1'b1;
            last_grant <= grant;
            o_ch_wsel  <= '0;
          end
        end
        DONE: begin
          last_grant <= grant;
          o_ch_wsel  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Controller handshake reaches only the granted channel, and only in XFER.
  assign xfer          = (state == XFER);
  assign o_wdata       = xfer ? wdata_g : '0;
  assign o_wready      = xfer & wready_g;
  assign o_ch_wdata_rq = xfer ? ({CH_NUM{i_wdata_rq}} & o_ch_wsel) : '0;
  assign o_ch_wbusy    = xfer ? ({CH_NUM{i_wbusy}} & o_ch_wsel) : '0;

endmodule

// File: tb/tb_mbus_wr_arbiter.sv
// Bench for mbus_wr_arbiter: round-robin and fixed-priority instances.
// Expected grants are queued when requests are driven and checked on o_wrq.
module tb_mbus_wr_arbiter;

  localparam int CH = 4;
  localparam int AW = 28;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst;
  logic [CH-1:0]    ch_wrq;
  logic [CH*AW-1:0] ch_waddr;
  logic [CH*DW-1:0] ch_wdata;
  logic [CH-1:0]    ch_wready;

  logic [CH-1:0] rr_wsel, rr_drq_o, rr_busy_o;
  logic          rr_wrq, rr_wready, rr_err;
  logic [AW-1:0] rr_waddr;
  logic [DW-1:0] rr_wdata;
  logic          rr_drq, rr_busy;

  logic [CH-1:0] fp_wsel, fp_drq_o, fp_busy_o;
  logic          fp_wrq, fp_wready, fp_err;
  logic [AW-1:0] fp_waddr;
  logic [DW-1:0] fp_wdata;
  logic          fp_drq, fp_busy;

  logic [AW-1:0] addr_tab [CH];
  logic [31:0]   exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mbus_wr_arbiter #(.ARB_MODE(0), .TIMEOUT(16)) dut_rr (
    .i_axi_aclk(clk), .i_rst(rst),
    .i_ch_wrq(ch_wrq), .i_ch_waddr(ch_waddr),
    .i_ch_wdata(ch_wdata), .i_ch_wready(ch_wready),
    .o_ch_wsel(rr_wsel), .o_ch_wdata_rq(rr_drq_o),
    .o_ch_wbusy(rr_busy_o), .o_wrq(rr_wrq),
    .o_waddr(rr_waddr), .o_wdata(rr_wdata),
    .o_wready(rr_wready), .i_wdata_rq(rr_drq),
    .i_wbusy(rr_busy), .o_err(rr_err)
  );

  mbus_wr_arbiter #(.ARB_MODE(1), .TIMEOUT(16)) dut_fp (
    .i_axi_aclk(clk), .i_rst(rst),
    .i_ch_wrq(ch_wrq), .i_ch_waddr(ch_waddr),
    .i_ch_wdata(ch_wdata), .i_ch_wready(ch_wready),
    .o_ch_wsel(fp_wsel), .o_ch_wdata_rq(fp_drq_o),
    .o_ch_wbusy(fp_busy_o), .o_wrq(fp_wrq),
    .o_waddr(fp_waddr), .o_wdata(fp_wdata),
    .o_wready(fp_wready), .i_wdata_rq(fp_drq),
    .i_wbusy(fp_busy), .o_err(fp_err)
  );

  task automatic load_addrs();
    for (int k = 0; k < CH; k++) begin
      addr_tab[k] = 28'h0100000 * 28'(k + 1) + 28'(k);
      ch_waddr[k*AW +: AW] = addr_tab[k];
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    ch_wrq    = '0;
    ch_wready = '0;
    ch_wdata  = '0;
    rr_drq    = 1'b0;
    rr_busy   = 1'b0;
    fp_drq    = 1'b0;
    fp_busy   = 1'b0;
    load_addrs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for o_wrq, plays the controller for one burst, returns in IDLE.
  task automatic wait_grant(input bit fp, input int nbusy,
                            output logic [CH-1:0] sel,
                            output logic [AW-1:0] addr,
                            output bit to);
    to   = 1'b1;
    sel  = '0;
    addr = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((fp ? fp_wrq : rr_wrq) === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
    if (!to) begin
      sel  = fp ? fp_wsel : rr_wsel;
      addr = fp ? fp_waddr : rr_waddr;
      if (fp) fp_busy = 1'b1;
      else rr_busy = 1'b1;
      repeat (nbusy) @(negedge clk);
      fp_busy = 1'b0;
      rr_busy = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({rr_wsel, rr_drq_o, rr_busy_o, rr_wrq, rr_wready, rr_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_rr_ctl got %b exp 0",
               {rr_wsel, rr_drq_o, rr_busy_o, rr_wrq, rr_wready, rr_err});
    end
    n_cmp++;
    if (rr_waddr !== '0 || rr_wdata !== '0) begin
      n_bad++;
      $display("FAIL reset_rr_data got addr %h data %h exp 0", rr_waddr, rr_wdata);
    end
    n_cmp++;
    if ({fp_wsel, fp_drq_o, fp_busy_o, fp_wrq, fp_wready, fp_err,
         fp_waddr, fp_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_fp got wsel %b wrq %b addr %h exp 0", fp_wsel, fp_wrq, fp_waddr);
    end
  endtask

  task automatic test_single();
    logic [31:0] e;
    do_reset();
    addr_tab[2] = 28'h0001000;
    ch_waddr[2*AW +: AW] = addr_tab[2];
    ch_wrq = 4'b0100;
    exp_q.push_back({4'b0100, addr_tab[2]});
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (rr_wsel !== e[31:28] || rr_wrq !== 1'b1 || rr_waddr !== e[27:0]) begin
      n_bad++;
      $display("FAIL single_grant got sel %b wrq %b addr %h exp %b 1 %h",
               rr_wsel, rr_wrq, rr_waddr, e[31:28], e[27:0]);
    end
    ch_wrq  = '0;
    rr_busy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rr_wrq !== 1'b0 || rr_busy_o !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_xfer got wrq %b busy %b exp 0 0100", rr_wrq, rr_busy_o);
    end
    repeat (7) @(negedge clk);
    rr_busy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rr_wsel !== 4'b0100 || rr_busy_o !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_done got sel %b busy %b exp 0100 0000", rr_wsel, rr_busy_o);
    end
    @(negedge clk);
    n_cmp++;
    if (rr_wsel !== 4'b0000 || rr_waddr !== 28'h0001000) begin
      n_bad++;
      $display("FAIL single_idle got sel %b addr %h exp 0000 0001000", rr_wsel, rr_waddr);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0]   e;
    logic [CH-1:0] sel, prev;
    logic [AW-1:0] addr;
    bit            to;
    do_reset();
    ch_wrq = 4'b1111;
    for (int i = 0; i < 6; i++) exp_q.push_back({4'(1 << (i % CH)), addr_tab[i % CH]});
    prev = '0;
    for (int i = 0; i < 6; i++) begin
      wait_grant(1'b0, 2, sel, addr, to);
      e = exp_q.pop_front();
      n_cmp++;
      if (to || sel !== e[31:28] || addr !== e[27:0]) begin
        n_bad++;
        $display("FAIL rr_order[%0d] got sel %b addr %h timeout %0d exp %b %h",
                 i, sel, addr, to, e[31:28], e[27:0]);
      end
      n_cmp++;
      if (sel === prev) begin
        n_bad++;
        $display("FAIL rr_repeat[%0d] got sel %b twice exp a different channel", i, sel);
      end
      prev = sel;
    end
    ch_wrq = '0;
  endtask

  task automatic test_fixed_priority();
    logic [31:0]   e;
    logic [CH-1:0] sel;
    logic [AW-1:0] addr;
    bit            to;
    do_reset();
    ch_wrq = 4'b1001;
    for (int i = 0; i < 3; i++) exp_q.push_back({4'b0001, addr_tab[0]});
    for (int i = 0; i < 3; i++) begin
      wait_grant(1'b1, 2, sel, addr, to);
      e = exp_q.pop_front();
      n_cmp++;
      if (to || sel !== e[31:28] || addr !== e[27:0]) begin
        n_bad++;
        $display("FAIL fp_ch0[%0d] got sel %b addr %h timeout %0d exp %b %h",
                 i, sel, addr, to, e[31:28], e[27:0]);
      end
    end
    ch_wrq = 4'b1000;
    exp_q.push_back({4'b1000, addr_tab[3]});
    wait_grant(1'b1, 2, sel, addr, to);
    ch_wrq = '0;
    e = exp_q.pop_front();
    n_cmp++;
    if (to || sel !== e[31:28] || addr !== e[27:0]) begin
      n_bad++;
      $display("FAIL fp_ch3 got sel %b addr %h timeout %0d exp %b %h",
               sel, addr, to, e[31:28], e[27:0]);
    end
  endtask

  task automatic test_timeout();
    logic [31:0]   e;
    logic [CH-1:0] sel;
    logic [AW-1:0] addr;
    bit            to;
    int            first_err, nerr;
    logic          wrq_at;
    do_reset();
    first_err = -1;
    nerr      = 0;
    wrq_at    = 1'bx;
    ch_wrq    = 4'b0010;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (rr_err === 1'b1) begin
        nerr++;
        if (first_err < 0) begin
          first_err = k;
          wrq_at    = rr_wrq;
        end
      end
      if (k == 16) begin
        ch_wrq = 4'b0110;
        exp_q.push_back({4'b0100, addr_tab[2]});
      end
    end
    n_cmp++;
    if (first_err != 16 || nerr != 1) begin
      n_bad++;
      $display("FAIL timeout_err got first %0d count %0d exp 16 1", first_err, nerr);
    end
    n_cmp++;
    if (wrq_at !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_wrq got %b exp 0", wrq_at);
    end
    wait_grant(1'b0, 2, sel, addr, to);
    ch_wrq = '0;
    e = exp_q.pop_front();
    n_cmp++;
    if (to || sel !== e[31:28] || addr !== e[27:0]) begin
      n_bad++;
      $display("FAIL timeout_next got sel %b addr %h timeout %0d exp %b %h",
               sel, addr, to, e[31:28], e[27:0]);
    end
  endtask

  task automatic test_xfer_mux();
    logic [31:0]   e;
    logic [DW-1:0] d3;
    logic          b;
    bit            seen;
    do_reset();
    for (int k = 0; k < CH; k++)
      ch_wdata[k*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
    ch_wready = 4'b1010;
    ch_wrq    = 4'b1000;
    exp_q.push_back({4'b1000, addr_tab[3]});
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rr_wrq === 1'b1) seen = 1'b1;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || rr_wsel !== e[31:28]) begin
      n_bad++;
      $display("FAIL mux_grant got sel %b seen %0d exp %b", rr_wsel, seen, e[31:28]);
    end
    ch_wrq  = '0;
    rr_busy = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      b      = t[0];
      rr_drq = b;
      d3     = {$urandom, $urandom, $urandom, $urandom};
      ch_wdata[3*DW +: DW] = d3;
      #1;
      n_cmp++;
      if (rr_drq_o !== {b, 3'b000} || rr_wready !== 1'b1) begin
        n_bad++;
        $display("FAIL mux_drq[%0d] got %b ready %b exp %b 1",
                 t, rr_drq_o, rr_wready, {b, 3'b000});
      end
      n_cmp++;
      if (rr_wdata !== d3) begin
        n_bad++;
        $display("FAIL mux_data[%0d] got %h exp %h", t, rr_wdata, d3);
      end
      @(negedge clk);
    end
    rr_busy = 1'b0;
    rr_drq  = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (rr_wdata !== '0 || rr_drq_o !== '0 || rr_wready !== 1'b0) begin
      n_bad++;
      $display("FAIL mux_outside got data %h drq %b ready %b exp 0",
               rr_wdata, rr_drq_o, rr_wready);
    end
    @(negedge clk);
    rr_drq = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0]   e;
    logic [CH-1:0] sel;
    logic [AW-1:0] addr;
    bit            to, seen;
    do_reset();
    ch_wrq = 4'b0010;
    exp_q.push_back({4'b0010, addr_tab[1]});
    wait_grant(1'b0, 2, sel, addr, to);
    ch_wrq = 4'b0100;
    e = exp_q.pop_front();
    n_cmp++;
    if (to || sel !== e[31:28]) begin
      n_bad++;
      $display("FAIL rst_pre got sel %b timeout %0d exp %b", sel, to, e[31:28]);
    end
    exp_q.push_back({4'b0100, addr_tab[2]});
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rr_wrq === 1'b1) seen = 1'b1;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || rr_wsel !== e[31:28]) begin
      n_bad++;
      $display("FAIL rst_ch2 got sel %b seen %0d exp %b", rr_wsel, seen, e[31:28]);
    end
    rr_busy = 1'b1;
    rr_drq  = 1'b1;
    @(negedge clk);
    rst    = 1'b1;
    ch_wrq = 4'b0101;
    @(negedge clk);
    n_cmp++;
    if ({rr_wsel, rr_drq_o, rr_busy_o, rr_wrq, rr_wready, rr_err,
         rr_waddr, rr_wdata} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid got sel %b drq %b busy %b wrq %b addr %h exp 0",
               rr_wsel, rr_drq_o, rr_busy_o, rr_wrq, rr_waddr);
    end
    rst     = 1'b0;
    rr_busy = 1'b0;
    rr_drq  = 1'b0;
    exp_q.push_back({4'b0001, addr_tab[0]});
    wait_grant(1'b0, 2, sel, addr, to);
    ch_wrq = '0;
    e = exp_q.pop_front();
    n_cmp++;
    if (to || sel !== e[31:28] || addr !== e[27:0]) begin
      n_bad++;
      $display("FAIL rst_after got sel %b addr %h timeout %0d exp %b %h",
               sel, addr, to, e[31:28], e[27:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_xfer_mux();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
